// File: rtl/mac_seq_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mac_seq_engine
//   Sequential unsigned multiply-accumulate engine. Each run takes N operand
//   pairs over a valid/ready handshake. Each pair goes through a W-cycle
//   shift-add multiplier, or skips it when either operand is zero. The
//   products are summed into an ACC_W-bit accumulator. A run either starts
//   from zero (mode=0) or continues from the previous result (mode=1).
//   Carries out of the accumulator set a sticky overflow flag.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   stf     in   start request, sampled only while idle
//   mode    in   sampled with stf: 0 = clear accumulator, 1 = accumulate on res
//   in_vld  in   operand pair valid
//   in_a    in   [W]     multiplicand
//   in_b    in   [W]     multiplier
//   in_rdy  out  engine waiting for an operand pair
//   eof     out  engine idle
//   done    out  one-cycle pulse when res has been updated
//   res     out  [ACC_W] result register
//   ovf     out  sticky accumulator overflow
// ---------------------------------------------------------------------------
module mac_seq_engine #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int ACC_W = 2*W + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stf,
  input  logic             mode,
  input  logic             in_vld,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             in_rdy,
  output logic             eof,
  output logic             done,
  output logic [ACC_W-1:0] res,
  output logic             ovf
);

  // The +1 keeps the counters at least one bit wide when N or W is 1.
  localparam int CNT_W = $clog2(N + 1);
  localparam int BIT_W = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MUL,
    S_ACC,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   res_q;
  logic               ovf_q;
  logic [2*W-1:0]     prod_q;
  logic [2*W-1:0]     mcand_q;
  logic [W-1:0]       mplier_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   term_cnt_q;
  logic               in_rdy_q;
  logic               eof_q;
  logic               done_q;

  // Partial-product step for the current multiplier bit.
  logic [2*W-1:0]     prod_d;
  // One extra bit catches the carry out of the accumulator.
  logic [ACC_W:0]     acc_sum_d;

  assign prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign acc_sum_d = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

  // in_rdy, eof and done are flops. They are set on the same edge as the
  // state change, so they match the state with no path from the inputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register is in the async reset, datapath included. A
    // mid-run abort therefore leaves no stale partial product or counter.
    if (!rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      bit_cnt_q  <= '0;
      term_cnt_q <= '0;
      in_rdy_q   <= 1'b0;
      eof_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // branch then reads the pre-edge values, whatever the statement order.
      case (state_q)
        S_IDLE: begin
          if (stf) begin
            state_q    <= S_WAIT;
            term_cnt_q <= '0;
            in_rdy_q   <= 1'b1;
            eof_q      <= 1'b0;
            if (mode) begin
              acc_q <= res_q;
            end else begin
              acc_q <= '0;
              ovf_q <= 1'b0;
            end
          end
        end

        S_WAIT: begin
          if (in_vld) begin
            mcand_q   <= {{W{1'b0}}, in_a};
            mplier_q  <= in_b;
            prod_q    <= '0;
            bit_cnt_q <= '0;
            in_rdy_q  <= 1'b0;
            // A zero operand gives a zero product, so the multiplier is skipped.
            state_q   <= (in_a == '0 || in_b == '0) ? S_ACC : S_MUL;
          end
        end

        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (bit_cnt_q == BIT_W'(W - 1)) begin
            state_q <= S_ACC;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        S_ACC: begin
          acc_q      <= acc_sum_d[ACC_W-1:0];
          term_cnt_q <= term_cnt_q + 1'b1;
          if (acc_sum_d[ACC_W]) begin
            ovf_q <= 1'b1;
          end
          if (term_cnt_q == CNT_W'(N - 1)) begin
            state_q <= S_DONE;
            res_q   <= acc_sum_d[ACC_W-1:0];
            done_q  <= 1'b1;
          end else begin
            state_q  <= S_WAIT;
            in_rdy_q <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          eof_q   <= 1'b1;
        end

        default: begin
          state_q  <= S_IDLE;
          in_rdy_q <= 1'b0;
          done_q   <= 1'b0;
          eof_q    <= 1'b1;
        end
      endcase
    end
  end

  assign in_rdy = in_rdy_q;
  assign eof    = eof_q;
  assign done   = done_q;
  assign res    = res_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mac_seq_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mac_seq_engine
//   Self-checking bench for mac_seq_engine at W=8, N=4. Directed runs come
//   from a table with hard expected results. Hand-written sequences cover
//   reset and abort. Random runs are compared against an arithmetic model
//   of the dot product. Inputs change and outputs are sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_mac_seq_engine;

  localparam int W      = 8;
  localparam int N      = 4;
  localparam int ACC_W  = 2*W + $clog2(N);
  localparam int BUDGET = 64;

  typedef struct packed {
    logic                   m;
    logic                   noise;
    logic [N-1:0][W-1:0]    a;
    logic [N-1:0][W-1:0]    b;
    logic [ACC_W-1:0]       exp_res;
    logic                   exp_ovf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             stf;
  logic             mode;
  logic             in_vld;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_rdy;
  logic             eof;
  logic             done;
  logic [ACC_W-1:0] res;
  logic             ovf;

  int               vectors;
  int               miscompares;
  int               cyc;

  // Model state: the last completed result and the sticky overflow.
  logic [ACC_W-1:0] model_res;
  logic             model_ovf;

  vec_t             tbl [6];

  mac_seq_engine #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .stf    (stf),
    .mode   (mode),
    .in_vld (in_vld),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_rdy (in_rdy),
    .eof    (eof),
    .done   (done),
    .res    (res),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from one accepted pair until in_rdy (or done) comes back.
  function automatic int term_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a != 0 && b != 0) ? W + 2 : 2;
  endfunction

  // Inputs used while the engine is busy. With noise set, every control and
  // data input is scrambled, and the engine must ignore all of it.
  task automatic drive_busy(input bit noise);
    in_a = W'($urandom);
    in_b = W'($urandom);
    mode = 1'($urandom);
    if (noise) begin
      in_vld = 1'($urandom);
      stf    = 1'($urandom);
    end else begin
      in_vld = 1'b1;
      stf    = 1'b0;
    end
  endtask

  // One complete run. The expected values follow from the arithmetic:
  // res = (start value + sum of a*b) mod 2^ACC_W; ovf is set when the true
  // sum reaches 2^ACC_W, and is kept from earlier runs only when mode=1.
  task automatic run(input logic m, input logic [N-1:0][W-1:0] a,
                     input logic [N-1:0][W-1:0] b, input bit noise);
    longint           sum;
    logic [ACC_W-1:0] prev_res;
    logic [ACC_W-1:0] exp_res;
    logic             exp_ovf;
    int               hs_cyc;
    int               cnt;

    sum = m ? longint'(model_res) : 0;
    for (int k = 0; k < N; k++) sum += longint'(a[k]) * longint'(b[k]);
    exp_res  = ACC_W'(sum % (longint'(1) << ACC_W));
    exp_ovf  = (m & model_ovf) | (sum >= (longint'(1) << ACC_W));
    prev_res = res;
    hs_cyc   = 0;

    check("idle_eof_before_start", eof, 1);
    stf    = 1'b1;
    mode   = m;
    in_vld = 1'b0;
    @(negedge clk);
    stf  = 1'b0;
    mode = 1'($urandom);
    check("start_to_rdy_latency", in_rdy, 1);

    for (int k = 0; k < N; k++) begin
      cnt = 0;
      while (!in_rdy && cnt < BUDGET) begin
        check("res_hold_during_run", res, prev_res);
        drive_busy(noise);
        @(negedge clk);
        cnt++;
      end
      if (!in_rdy) begin
        check("in_rdy_timeout", 0, 1);
        stf = 1'b0; in_vld = 1'b0;
        return;
      end
      check("eof_low_in_wait", eof, 0);
      if (k > 0) check("handshake_spacing", cyc - hs_cyc, term_cycles(a[k-1], b[k-1]));
      hs_cyc = cyc;
      stf    = 1'b0;
      in_a   = a[k];
      in_b   = b[k];
      in_vld = 1'b1;
      @(negedge clk);
    end

    stf    = 1'b0;
    in_vld = 1'b0;
    cnt    = 0;
    while (!done && cnt < BUDGET) begin
      check("res_hold_during_run", res, prev_res);
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("done_latency", cyc - hs_cyc, term_cycles(a[N-1], b[N-1]));
    check("res_at_done", res, exp_res);
    check("ovf_at_done", ovf, exp_ovf);
    check("in_rdy_low_at_done", in_rdy, 0);
    model_res = exp_res;
    model_ovf = exp_ovf;
    @(negedge clk);
    check("done_single_cycle", done, 0);
    check("eof_after_done", eof, 1);
    check("res_held_after_done", res, exp_res);
  endtask

  // Waits for in_rdy, then offers one pair for exactly one cycle.
  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    int cnt;
    cnt = 0;
    while (!in_rdy && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
    end
    check("offer_in_rdy", in_rdy, 1);
    in_a   = a;
    in_b   = b;
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  initial begin
    logic [N-1:0][W-1:0] ra;
    logic [N-1:0][W-1:0] rb;
    logic                rm;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    model_res   = '0;
    model_ovf   = 1'b0;
    stf = 1'b0; mode = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0;
    rst = 1'b1;

    // Directed runs. Each row starts from the result the previous row left.
    tbl[0] = '{m: 1'b0, noise: 1'b0, a: {8'd255, 8'd0, 8'd2, 8'd3},
               b: {8'd255, 8'd9, 8'd7, 8'd5}, exp_res: 18'd65054, exp_ovf: 1'b0};
    tbl[1] = '{m: 1'b1, noise: 1'b0, a: {8'd255, 8'd0, 8'd2, 8'd3},
               b: {8'd255, 8'd9, 8'd7, 8'd5}, exp_res: 18'd130108, exp_ovf: 1'b0};
    tbl[2] = '{m: 1'b0, noise: 1'b0, a: {4{8'd255}}, b: {4{8'd255}},
               exp_res: 18'd260100, exp_ovf: 1'b0};
    tbl[3] = '{m: 1'b1, noise: 1'b0, a: {4{8'd255}}, b: {4{8'd255}},
               exp_res: 18'd258056, exp_ovf: 1'b1};
    tbl[4] = '{m: 1'b0, noise: 1'b0, a: {8'd0, 8'd0, 8'd0, 8'd1},
               b: {8'd0, 8'd0, 8'd0, 8'd1}, exp_res: 18'd1, exp_ovf: 1'b0};
    // Input noise while busy: only the pairs seen in WAIT count.
    // 7*9 + 200*3 + 1*255 + 17*0 = 918
    tbl[5] = '{m: 1'b0, noise: 1'b1, a: {8'd17, 8'd1, 8'd200, 8'd7},
               b: {8'd0, 8'd255, 8'd3, 8'd9}, exp_res: 18'd918, exp_ovf: 1'b0};

    // Reset asserted between clock edges must act at once.
    #3 rst = 1'b0;
    #1;
    check("reset_res", res, 0);
    check("reset_ovf", ovf, 0);
    check("reset_done", done, 0);
    check("reset_in_rdy", in_rdy, 0);
    check("reset_eof", eof, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold_flags", {eof, in_rdy, done}, 3'b100);
      check("idle_hold_res", res, 0);
    end

    // Table-driven runs.
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].noise);
      check("table_res", res, tbl[i].exp_res);
      check("table_ovf", ovf, tbl[i].exp_ovf);
    end

    // Abort: reset during the 4th MUL cycle of the second term.
    stf = 1'b1; mode = 1'b0;
    @(negedge clk);
    stf = 1'b0;
    offer(8'd3, 8'd4);
    offer(8'd5, 8'd6);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_res", res, 0);
    check("abort_ovf", ovf, 0);
    check("abort_flags", {eof, in_rdy, done}, 3'b100);
    model_res = '0;
    model_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_abort_idle", {eof, in_rdy, done}, 3'b100);
    end
    run(1'b0, {4{8'd1}}, {4{8'd2}}, 1'b0);
    check("post_abort_res", res, 8);

    // Random runs against the arithmetic model.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        ra[k] = ($urandom_range(3) == 0) ? '0 : W'($urandom);
        rb[k] = ($urandom_range(3) == 0) ? '0 : W'($urandom);
      end
      rm = 1'($urandom);
      run(rm, ra, rb, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
